// File: rtl/fib_lpm_table.sv
// Longest-prefix-match FIB: hashed single-port table of {valid, len, masked prefix, face} entries.
// Define FIB_DEFAULT_ROUTE_EN to add default_en/default_face, which turn a final miss into a hit on default_face.
module fib_lpm_table #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int HASH_W   = 10,
  parameter int FACE_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_valid,
  output logic                ins_ready,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  input  logic [FACE_W-1:0]   ins_face,
  output logic                ins_evict,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [PREFIX_W-1:0] lk_prefix,
  input  logic [LEN_W-1:0]    lk_len,
  output logic                res_valid,
  output logic                res_hit,
  output logic [FACE_W-1:0]   res_face,
  output logic [LEN_W-1:0]    res_len,
`ifdef FIB_DEFAULT_ROUTE_EN
  input  logic                default_en,
  input  logic [FACE_W-1:0]   default_face,
`endif
  output logic                busy
);

  localparam int DEPTH  = 1 << HASH_W;
  localparam int NSLICE = (PREFIX_W + HASH_W - 1) / HASH_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_PROBE, S_CMP} state_t;

  typedef struct packed {
    logic                valid;
    logic [LEN_W-1:0]    len;
    logic [PREFIX_W-1:0] prefix;
    logic [FACE_W-1:0]   face;
  } entry_t;

  function automatic logic [PREFIX_W-1:0] f_mask(input logic [PREFIX_W-1:0] p,
                                                 input logic [LEN_W-1:0]    l);
    return p & ~({PREFIX_W{1'b1}} >> l);
  endfunction

  // Slices are taken from the LSB upward, so the zero padding lands in the top slice.
  function automatic logic [HASH_W-1:0] f_idx(input logic [PREFIX_W-1:0] p,
                                              input logic [LEN_W-1:0]    l);
    logic [NSLICE*HASH_W-1:0] v;
    logic [HASH_W-1:0]        acc;
    v   = (NSLICE*HASH_W)'(f_mask(p, l));
    acc = HASH_W'(l);
    for (int i = 0; i < NSLICE; i++) acc ^= v[i*HASH_W +: HASH_W];
    return acc;
  endfunction

  function automatic logic [LEN_W-1:0] f_clamp(input logic [LEN_W-1:0] l);
    if (int'(l) > PREFIX_W - 1) return LEN_W'(PREFIX_W - 1);
    return l;
  endfunction

  state_t              r_state, w_next_state;
  logic [HASH_W-1:0]   r_init_cnt;
  logic [PREFIX_W-1:0] r_prefix;
  logic [LEN_W-1:0]    r_cur_len;
  logic                r_ins_pend;
  logic [LEN_W-1:0]    r_ins_len;
  logic [PREFIX_W-1:0] r_ins_prefix;
  logic                r_res_valid, r_res_hit;
  logic [FACE_W-1:0]   r_res_face;
  logic [LEN_W-1:0]    r_res_len;
  entry_t              r_mem [DEPTH];
  entry_t              r_rdata;

  logic                w_ins_fire, w_lk_fire, w_hit, w_we;
  logic [PREFIX_W-1:0] w_ins_mask;
  logic [HASH_W-1:0]   w_addr;
  entry_t              w_wdata;
  logic                w_miss_hit;
  logic [FACE_W-1:0]   w_miss_face;

  assign ins_ready  = (r_state == S_IDLE);
  assign lk_ready   = (r_state == S_IDLE) & ~ins_valid;
  assign busy       = (r_state != S_IDLE);
  assign w_ins_fire = ins_valid & ins_ready;
  assign w_lk_fire  = lk_valid & lk_ready;
  assign w_ins_mask = f_mask(ins_prefix, ins_len);
  assign w_hit      = r_rdata.valid && (r_rdata.len == r_cur_len) &&
                      (r_rdata.prefix == f_mask(r_prefix, r_cur_len));
  assign ins_evict  = r_ins_pend && r_rdata.valid &&
                      ({r_rdata.len, r_rdata.prefix} != {r_ins_len, r_ins_prefix});

`ifdef FIB_DEFAULT_ROUTE_EN
  assign w_miss_hit  = default_en;
  assign w_miss_face = default_en ? default_face : '0;
`else
  assign w_miss_hit  = 1'b0;
  assign w_miss_face = '0;
`endif

  // One shared port: the INIT sweep and inserts write, every cycle reads (old data on collision).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_we    = 1'b0;
    w_addr  = f_idx(r_prefix, r_cur_len);
    w_wdata = '0;
    if (r_state == S_INIT) begin
      w_we   = 1'b1;
      w_addr = r_init_cnt;
    end else if (w_ins_fire) begin
      w_we    = 1'b1;
      w_addr  = f_idx(ins_prefix, ins_len);
      w_wdata = {1'b1, ins_len, w_ins_mask, ins_face};
    end
  end

  // NOTE: the table array has no reset; the INIT sweep clears valid bits instead.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
    r_rdata <= r_mem[w_addr];
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == HASH_W'(DEPTH - 1)) w_next_state = S_IDLE;
      S_IDLE:  if (w_lk_fire) w_next_state = S_PROBE;
      S_PROBE: w_next_state = S_CMP;
      S_CMP:   if (w_hit || r_cur_len == '0) w_next_state = S_IDLE;
               else w_next_state = S_PROBE;
      default: w_next_state = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_init_cnt   <= '0;
      r_prefix     <= '0;
      r_cur_len    <= '0;
      r_ins_pend   <= 1'b0;
      r_ins_len    <= '0;
      r_ins_prefix <= '0;
      r_res_valid  <= 1'b0;
      r_res_hit    <= 1'b0;
      r_res_face   <= '0;
      r_res_len    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_res_valid <= 1'b0;
      r_ins_pend  <= w_ins_fire;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + HASH_W'(1);
      if (w_ins_fire) begin
        r_ins_len    <= ins_len;
        r_ins_prefix <= w_ins_mask;
      end
      if (w_lk_fire) begin
        r_prefix  <= lk_prefix;
        r_cur_len <= f_clamp(lk_len);
      end
      if (r_state == S_CMP) begin
        if (w_hit) begin
          r_res_valid <= 1'b1;
          r_res_hit   <= 1'b1;
          r_res_face  <= r_rdata.face;
          r_res_len   <= r_cur_len;
        end else if (r_cur_len == '0) begin
          r_res_valid <= 1'b1;
          r_res_hit   <= w_miss_hit;
          r_res_face  <= w_miss_face;
          r_res_len   <= '0;
        end else begin
          r_cur_len <= r_cur_len - LEN_W'(1);
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_hit   = r_res_hit;
  assign res_face  = r_res_face;
  assign res_len   = r_res_len;

endmodule

// File: tb/tb_fib_lpm_table.sv
// Directed bench for fib_lpm_table: reset sweep, LPM, aliasing, insert/lookup collision, reset mid-lookup.
// With FIB_DEFAULT_ROUTE_EN defined it also checks the default-route miss path.
module tb_fib_lpm_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0, lk_valid = 1'b0;
  logic [63:0] ins_prefix = '0, lk_prefix = '0;
  logic [5:0]  ins_len = '0, lk_len = '0;
  logic [1:0]  ins_face = '0;
  logic        ins_ready, ins_evict, lk_ready, res_valid, res_hit, busy;
  logic [1:0]  res_face;
  logic [5:0]  res_len;
`ifdef FIB_DEFAULT_ROUTE_EN
  logic        default_en = 1'b0;
  logic [1:0]  default_face = '0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fib_lpm_table dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_prefix(ins_prefix),
    .ins_len(ins_len), .ins_face(ins_face), .ins_evict(ins_evict),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_prefix(lk_prefix), .lk_len(lk_len),
    .res_valid(res_valid), .res_hit(res_hit), .res_face(res_face), .res_len(res_len),
`ifdef FIB_DEFAULT_ROUTE_EN
    .default_en(default_en), .default_face(default_face),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call between the reset edge and the next posedge.
  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_ins_ready"}, ins_ready, 1'b0);
    check({tag, "_lk_ready"},  lk_ready,  1'b0);
    check({tag, "_ins_evict"}, ins_evict, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_hit"},   res_hit,   1'b0);
    check({tag, "_res_face"},  res_face,  2'd0);
    check({tag, "_res_len"},   res_len,   6'd0);
    check({tag, "_busy"},      busy,      1'b1);
  endtask

  task automatic wait_init(input string tag, output bit saw_res);
    int n;
    n = 0;
    saw_res = 1'b0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (res_valid) saw_res = 1'b1;
      if (!busy) break;
    end
    check({tag, "_init_cycles"}, n, 1024);
    check({tag, "_ins_ready_up"}, ins_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic insert(input string tag, input logic [63:0] p, input logic [5:0] l,
                        input logic [1:0] f, input logic exp_evict);
    @(posedge clk);
    #1;
    ins_valid = 1'b1; ins_prefix = p; ins_len = l; ins_face = f;
    @(negedge clk);
    check({tag, "_ins_ready"}, ins_ready, 1'b1);
    @(posedge clk);
    #1 ins_valid = 1'b0;
    @(negedge clk);
    check({tag, "_evict"}, ins_evict, exp_evict);
  endtask

  // Call just after the accept edge; latency counts edges from accept to the strobe.
  task automatic finish_lookup(input string tag, input logic exp_hit, input logic [1:0] exp_face,
                               input logic [5:0] exp_len, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_hit"},  res_hit,  exp_hit);
    check({tag, "_face"}, res_face, exp_face);
    check({tag, "_len"},  res_len,  exp_len);
  endtask

  task automatic lookup(input string tag, input logic [63:0] p, input logic [5:0] l,
                        input logic exp_hit, input logic [1:0] exp_face,
                        input logic [5:0] exp_len, input int exp_lat);
    @(posedge clk);
    #1;
    lk_valid = 1'b1; lk_prefix = p; lk_len = l;
    @(negedge clk);
    check({tag, "_lk_ready"}, lk_ready, 1'b1);
    @(posedge clk);
    #1 lk_valid = 1'b0;
    finish_lookup(tag, exp_hit, exp_face, exp_len, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;

    // Reset clear sweep and empty-table worst-case miss.
    do_reset();
    check_reset_vals("rst0");
    wait_init("rst0", saw);
    lookup("empty63", 64'hDEAD_BEEF_0000_0001, 6'd63, 1'b0, 2'd0, 6'd0, 128);

    // Longest-prefix match; the two routes hash to 0x2C2 and 0x3E9.
    insert("ins_ab8",    64'hAB00_0000_0000_0000, 6'd8,  2'd1, 1'b0);
    insert("ins_abcd16", 64'hABCD_0000_0000_0000, 6'd16, 2'd2, 1'b0);
    lookup("lpm16", 64'hABCD_1234_0000_0000, 6'd32, 1'b1, 2'd2, 6'd16, 34);
    lookup("lpm8",  64'hABEE_0000_0000_0000, 6'd16, 1'b1, 2'd1, 6'd8,  18);
    @(negedge clk);
    check("hold_strobe", res_valid, 1'b0);
    check("hold_face",   res_face,  2'd1);
    // Bits below len are ignored, so this rewrites the 0xAB/8 route in place.
    insert("upd_ab8", 64'hABFF_FFFF_FFFF_FFFF, 6'd8, 2'd3, 1'b0);
    lookup("upd_lk",  64'hAB12_0000_0000_0000, 6'd8,  1'b1, 2'd3, 6'd8,  2);
    lookup("keep16",  64'hABCD_0000_0000_0000, 6'd16, 1'b1, 2'd2, 6'd16, 2);

    // Insert and lookup requested together: insert wins, lookup follows next cycle.
    @(posedge clk);
    #1;
    ins_valid = 1'b1; ins_prefix = 64'h1234_5678_0000_0000; ins_len = 6'd32; ins_face = 2'd2;
    lk_valid = 1'b1;  lk_prefix = 64'h1234_5678_0000_0000;  lk_len = 6'd32;
    @(negedge clk);
    check("coll_ins_ready", ins_ready, 1'b1);
    check("coll_lk_ready0", lk_ready,  1'b0);
    @(posedge clk);
    #1 ins_valid = 1'b0;
    @(negedge clk);
    check("coll_lk_ready1", lk_ready,  1'b1);
    check("coll_evict",     ins_evict, 1'b0);
    @(posedge clk);
    #1 lk_valid = 1'b0;
    finish_lookup("coll", 1'b1, 2'd2, 6'd32, 2);

    // Alias: prefix bits 59 and 49 sit at the same slice offset, so both routes index 30.
    do_reset();
    check_reset_vals("rst1");
    wait_init("rst1", saw);
    insert("alias_a", 64'h0000_0000_0000_0000, 6'd30, 2'd1, 1'b0);
    insert("alias_b", 64'h0802_0000_0000_0000, 6'd30, 2'd2, 1'b1);
    lookup("alias_a_lk", 64'h0000_0000_0000_0000, 6'd30, 1'b0, 2'd0, 6'd0,  62);
    lookup("alias_b_lk", 64'h0802_0000_0000_0000, 6'd30, 1'b1, 2'd2, 6'd30, 2);

    // Reset while the first probe of a hitting lookup sits in CMP.
    @(posedge clk);
    #1;
    lk_valid = 1'b1; lk_prefix = 64'h0802_0000_0000_0000; lk_len = 6'd30;
    @(posedge clk);
    #1 lk_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("midrst");
    wait_init("midrst", saw);
    check("midrst_no_res", saw, 1'b0);
    lookup("midrst_gone", 64'h0802_0000_0000_0000, 6'd30, 1'b0, 2'd0, 6'd0, 62);

`ifdef FIB_DEFAULT_ROUTE_EN
    default_en = 1'b1;
    default_face = 2'd3;
    lookup("dflt", 64'h5555_0000_0000_0000, 6'd4, 1'b1, 2'd3, 6'd0, 10);
    default_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
